// File: rtl/txid_return_unit.sv
// txid_return_unit: return side of the transaction-ID pool.
// Tracks IDs popped from the free-list FIFO, collects out-of-order
// completions against them, and pushes completed IDs back into the free
// list. Also reports outstanding IDs, the in-flight count and a sticky
// protocol-error flag.

// Per-ID lifecycle: free -> outstanding -> pending (completed) -> free.
module txid_slot (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic alloc_i,   // ID handed out this cycle (already validated)
    input  logic done_i,    // last beat for this ID while outstanding
    input  logic ret_i,     // push of this ID accepted by the free list
    output logic out_o,
    output logic pend_o
);
    // alloc/done and done/ret can never target the same ID in one cycle:
    // alloc needs the slot idle, done needs it outstanding, ret needs it pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_o  <= 1'b0;
            pend_o <= 1'b0;
        end else if (flush_i) begin
            out_o  <= 1'b0;
            pend_o <= 1'b0;
        end else begin
            if (alloc_i)     out_o <= 1'b1;
            else if (done_i) out_o <= 1'b0;
            if (done_i)      pend_o <= 1'b1;
            else if (ret_i)  pend_o <= 1'b0;
        end
    end
endmodule

module txid_return_unit #(
    parameter int NUM_IDS   = 8,
    parameter int ID_WIDTH  = $clog2(NUM_IDS),
    parameter int CNT_WIDTH = $clog2(NUM_IDS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 alloc_valid_i,
    input  logic [ID_WIDTH-1:0]  alloc_id_i,
    input  logic                 rsp_valid_i,
    input  logic [ID_WIDTH-1:0]  rsp_id_i,
    input  logic                 rsp_last_i,
    output logic                 ret_valid_o,
    output logic [ID_WIDTH-1:0]  ret_id_o,
    input  logic                 ret_full_i,
    output logic [NUM_IDS-1:0]   outstanding_o,
    output logic [CNT_WIDTH-1:0] inflight_cnt_o,
    output logic                 idle_o,
    output logic                 err_o
);
    logic [NUM_IDS-1:0]   outstanding_q;
    logic [NUM_IDS-1:0]   pending_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 err_q;
    logic                 hold_vld_q;
    logic [ID_WIDTH-1:0]  hold_id_q;

    logic                alloc_in_rng, rsp_in_rng;
    logic                alloc_ok, alloc_err;
    logic                rsp_hit, rsp_err, rsp_done;
    logic                low_vld;
    logic [ID_WIDTH-1:0] low_id;
    logic                ret_acc;

    // Out-of-range IDs (non power-of-two pools) are treated as protocol errors.
    assign alloc_in_rng = 32'(alloc_id_i) < NUM_IDS;
    assign rsp_in_rng   = 32'(rsp_id_i) < NUM_IDS;

    // Judged on pre-update state: an alloc colliding with a same-cycle
    // completion finds the ID still outstanding and is flagged.
    assign alloc_ok  = alloc_valid_i && alloc_in_rng &&
                       !outstanding_q[alloc_id_i] && !pending_q[alloc_id_i];
    assign alloc_err = alloc_valid_i && !alloc_ok;

    assign rsp_hit  = rsp_valid_i && rsp_in_rng && outstanding_q[rsp_id_i];
    assign rsp_err  = rsp_valid_i && !rsp_hit;
    assign rsp_done = rsp_hit && rsp_last_i;

    // Lowest-index pending ID, scanned high to low so the last hit wins.
    always_comb begin
        low_vld = 1'b0;
        low_id  = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_vld = 1'b1;
                low_id  = ID_WIDTH'(i);
            end
        end
    end

    // While stalled the registered pick wins, so the push data stays stable.
    assign ret_valid_o = low_vld && !flush_i;
    assign ret_id_o    = hold_vld_q ? hold_id_q : low_id;
    assign ret_acc     = ret_valid_o && !ret_full_i;

    genvar g;
    generate
        for (g = 0; g < NUM_IDS; g++) begin : g_slot
            txid_slot u_slot (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .flush_i (flush_i),
                .alloc_i (alloc_ok && (alloc_id_i == ID_WIDTH'(g))),
                .done_i  (rsp_done && (rsp_id_i == ID_WIDTH'(g))),
                .ret_i   (ret_acc && (ret_id_o == ID_WIDTH'(g))),
                .out_o   (outstanding_q[g]),
                .pend_o  (pending_q[g])
            );
        end
    endgenerate

    // In-flight count, sticky error and the stalled-return selection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            err_q      <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_id_q  <= '0;
        end else if (flush_i) begin
            cnt_q      <= '0;
            err_q      <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_id_q  <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(alloc_ok) - CNT_WIDTH'(ret_acc);
            err_q <= err_q | alloc_err | rsp_err;
            if (ret_valid_o && ret_full_i) begin
                hold_vld_q <= 1'b1;
                hold_id_q  <= ret_id_o;
            end else if (ret_acc) begin
                hold_vld_q <= 1'b0;
            end
        end
    end

    assign outstanding_o  = outstanding_q;
    assign inflight_cnt_o = cnt_q;
    assign idle_o         = (cnt_q == '0);
    assign err_o          = err_q;
endmodule
